ext_pipe: RTL and testbench
===========================

# ext_pipe

Registered, parametrised immediate/data extension unit for the D-stage and M/W-stage of the pipelined MIPS core. Each accepted request (op, imm, shamt, load word, byte address) is extended into a DATA_W result that emerges one cycle later through a 2-entry skid buffer with valid/ready handshakes on both sides. Compared with the plain combinational extender, it adds `lui` and load-data (`lb`/`lbu`/`lh`/`lhu`) modes and defined error reporting. Undefined ops and misaligned accesses produce 0, never z.

## Interface

**Parameters** (`DATA_W` ≥ 2·`IMM_W`; `DATA_W` must be a power of two ≥ 16)
- `DATA_W`, default 32: result and load-word width.
- `IMM_W`, default 16: immediate width.
- `SHAMT_W`, default 5: shift-amount width.
- `LANE_W`, default `$clog2(DATA_W/8)`: byte-address width. Derived; do not override.

**Ports**
- `clk`  in  1  — the single clock; all state on the rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `flush`  in  1  — synchronous; empties the buffer.
- `in_valid`  in  1  — request valid.
- `in_ready`  out  1  — unit can accept a request.
- `ext_op`  in  3  — operation select.
- `imm`  in  IMM_W  — immediate.
- `shamt`  in  SHAMT_W  — shift amount.
- `din`  in  DATA_W  — load word from memory.
- `addr`  in  LANE_W  — low byte-address bits.
- `out_valid`  out  1  — result valid.
- `out_ready`  in  1  — consumer accepts the result.
- `ext`  out  DATA_W  — result.
- `err`  out  1  — result belongs to an illegal or misaligned request.
- `count`  out  2  — buffer occupancy, 0..2.

## Operation

**Result computation** (combinational from the inputs; captured on push)
- op 0: sign-extend `imm`.
- op 1: zero-extend `imm`.
- op 2: zero-extend `shamt`.
- op 3 (`lui`): `imm` placed in bits [2·IMM_W-1:IMM_W]; all other bits 0; upper bits zero-filled.
- op 4 / op 5 (`lb` / `lbu`): select byte `din[8·addr +: 8]`, then sign-extend (op 4) or zero-extend (op 5).
- op 6 / op 7 (`lh` / `lhu`): select half-word `din[16·addr[LANE_W-1:1] +: 16]`, then sign-extend (op 6) or zero-extend (op 7).
- If `addr[0]`=1 on op 6/7: `ext`=0, `err`=1.
- `err`=0 for every other legal case.

**Buffer**
- 2-entry FIFO: storage is two {ext, err} slots plus read pointer, write pointer and count.
- Push = `in_valid & in_ready`.
- Pop = `out_valid & out_ready`.
- Push and pop in the same cycle: count is unchanged, and ordering is preserved.
- `in_ready` = (count < 2). It is combinational from registered count only and never depends on `out_ready`.
- `out_valid` = (count != 0). `ext`/`err` always show the head slot; they read 0 when empty.

**Flush**
- Next cycle: count=0, pointers=0, `out_valid`=0.
- Flush in the same cycle as a push: flush wins; the pushed request is discarded.
- Flush in the same cycle as a pop: the pop is also void.

**Reset**
- Asynchronous on `rst_n` low, at any time including mid-transfer.
- count=0, pointers=0, `out_valid`=0, `in_ready`=1, `ext`=0, `err`=0.
- Storage slots cleared to 0.

## Timing

- Latency: request pushed at edge N appears on `ext` with `out_valid`=1 after edge N (cycle N+1).
- Throughput: 1 per cycle while `out_ready`=1.
- Full (count=2): `in_ready`=0. A push is blocked even if `out_ready`=1 that cycle (no combinational bypass).
- Empty with `out_ready`=1: no pop and no underflow; `count` remains 0.
- Pointers wrap 1→0.

## Configuration

- `EXT_PIPE_LOAD_EN` defined: ops 4–7 implemented as above.
- `EXT_PIPE_LOAD_EN` undefined:
  - ops 4–7 yield `ext`=0, `err`=1.
  - `din` and `addr` are unused; the selection logic is removed.
  - Handshake behaviour is identical in both builds.

## Test plan

All vectors use default parameters.

1. **Reset.** Drive `rst_n`=0 mid-stream with count=2 → immediately count=0, `out_valid`=0, `ext`=0, `err`=0, `in_ready`=1.
2. **Immediate modes, streaming.** `out_ready`=1; push ops 0/1/2/3 with `imm`=16'h8001 and `shamt`=5'h1F → next cycles give `ext` = 32'hFFFF8001, 32'h00008001, 32'h0000001F, 32'h80010000; `err`=0.
3. **Load modes.** `din`=32'h80FF7F01:
   - op 4, `addr`=2 → 32'hFFFFFFFF
   - op 5, `addr`=3 → 32'h00000080
   - op 6, `addr`=2 → 32'hFFFF80FF
   - op 7, `addr`=0 → 32'h00007F01
   - op 6, `addr`=1 → `ext`=0, `err`=1
   - Without `EXT_PIPE_LOAD_EN`: all five → `ext`=0, `err`=1.
4. **Backpressure.** `out_ready`=0; push A, B → count=2, `in_ready`=0. A third push is held. Raise `out_ready` → A, then B, then C delivered in order with no loss or duplication.
5. **Flush.** count=1, assert `flush` together with a push of op 1 `imm`=16'h0005 → next cycle count=0, `out_valid`=0; the pushed value never appears.
6. **Simultaneous push/pop.** At count=1, push and pop every cycle for 10 cycles → count stays 1, and the outputs match the input sequence delayed by one element.

Source files
------------

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - registered immediate/load-data extension unit with 2-entry skid buffer (optional load modes: EXT_PIPE_LOAD_EN)
module ext_pipe #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int LANE_W  = $clog2(DATA_W / 8)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         ext_op,
    input  logic [IMM_W-1:0]   imm,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [DATA_W-1:0]  din,
    input  logic [LANE_W-1:0]  addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  ext,
    output logic               err,
    output logic [1:0]         count
);

    localparam logic [2:0] OP_SEXT  = 3'd0;
    localparam logic [2:0] OP_ZEXT  = 3'd1;
    localparam logic [2:0] OP_SHAMT = 3'd2;
    localparam logic [2:0] OP_LUI   = 3'd3;
    localparam logic [2:0] OP_LB    = 3'd4;
    localparam logic [2:0] OP_LBU   = 3'd5;
    localparam logic [2:0] OP_LH    = 3'd6;
    localparam logic [2:0] OP_LHU   = 3'd7;

    logic [DATA_W-1:0] res_ext;
    logic              res_err;

    logic [DATA_W-1:0] slot_ext_q [2];
    logic              slot_err_q [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;

    logic push;
    logic pop;

`ifdef EXT_PIPE_LOAD_EN
    // Shifting by 8*addr lines the addressed byte up at bit 0; for an aligned
    // half-word address 16*(addr>>1) equals 8*addr, so the same shift serves both.
    logic [DATA_W-1:0] load_shifted;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic              load_unused;

    assign load_shifted = din >> {addr, 3'b000};
    assign load_byte    = load_shifted[7:0];
    assign load_half    = load_shifted[15:0];
    assign load_unused  = ^load_shifted[DATA_W-1:16];
`else
    // Load path removed in this build; the inputs are deliberately ignored.
    logic ext_unused;
    assign ext_unused = ^{din, addr};
`endif

    // Result computation for the request currently offered on the input side.
    always_comb begin
        res_ext = '0;
        res_err = 1'b0;
        case (ext_op)
            OP_SEXT:  res_ext = DATA_W'($signed(imm));
            OP_ZEXT:  res_ext = DATA_W'(imm);
            OP_SHAMT: res_ext = DATA_W'(shamt);
            OP_LUI:   res_ext = DATA_W'(imm) << IMM_W;
`ifdef EXT_PIPE_LOAD_EN
            OP_LB:    res_ext = DATA_W'($signed(load_byte));
            OP_LBU:   res_ext = DATA_W'(load_byte);
            OP_LH, OP_LHU: begin
                if (addr[0]) begin
                    res_ext = '0;
                    res_err = 1'b1;
                end else if (ext_op == OP_LH) begin
                    res_ext = DATA_W'($signed(load_half));
                end else begin
                    res_ext = DATA_W'(load_half);
                end
            end
`else
            OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                res_ext = '0;
                res_err = 1'b1;
            end
`endif
            default: begin
                res_ext = '0;
                res_err = 1'b1;
            end
        endcase
    end

    // Handshake: acceptance depends only on registered occupancy, flush voids both sides.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign count     = count_q;
    assign ext       = out_valid ? slot_ext_q[rd_ptr_q] : '0;
    assign err       = out_valid ? slot_err_q[rd_ptr_q] : 1'b0;

    // Next-state for pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot storage: capture the computed result into the write slot on push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_ext_q[0] <= '0;
            slot_ext_q[1] <= '0;
            slot_err_q[0] <= 1'b0;
            slot_err_q[1] <= 1'b0;
        end else if (push) begin
            slot_ext_q[wr_ptr_q] <= res_ext;
            slot_err_q[wr_ptr_q] <= res_err;
        end
    end

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - directed self-checking bench for ext_pipe
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ext_op;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic [31:0] din;
    logic [1:0]  addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ext;
    logic        err;
    logic [1:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    ext_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ext_op    (ext_op),
        .imm       (imm),
        .shamt     (shamt),
        .din       (din),
        .addr      (addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ext       (ext),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [2:0] op, input logic [15:0] im,
                           input logic [4:0] sh, input logic [31:0] d, input logic [1:0] a);
        in_valid = v;
        ext_op   = op;
        imm      = im;
        shamt    = sh;
        din      = d;
        addr     = a;
    endtask

    logic [2:0]  imm_ops  [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] imm_exp  [4] = '{32'hFFFF8001, 32'h00008001, 32'h0000001F, 32'h80010000};
    logic [2:0]  ld_ops   [5] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
    logic [1:0]  ld_addr  [5] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd1};
`ifdef EXT_PIPE_LOAD_EN
    logic [31:0] ld_exp   [5] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h0};
    logic        ld_err   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
    logic [31:0] ld_exp   [5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic        ld_err   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_req(1'b0, 3'd0, 16'h0, 5'h0, 32'h0, 2'd0);
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ext", ext, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // immediate modes, streaming
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(1'b1, imm_ops[i], 16'h8001, 5'h1F, 32'h0, 2'd0);
            tick();
            check($sformatf("imm_ext_%0d", i), ext, imm_exp[i]);
            check($sformatf("imm_err_%0d", i), 32'(err), 32'd0);
            check($sformatf("imm_valid_%0d", i), 32'(out_valid), 32'd1);
        end
        set_req(1'b0, 3'd0, 16'h0, 5'h0, 32'h0, 2'd0);
        tick();
        check("drain_count", 32'(count), 32'd0);

        // load modes
        for (int i = 0; i < 5; i++) begin
            set_req(1'b1, ld_ops[i], 16'h0, 5'h0, 32'h80FF7F01, ld_addr[i]);
            tick();
            check($sformatf("ld_ext_%0d", i), ext, ld_exp[i]);
            check($sformatf("ld_err_%0d", i), 32'(err), 32'(ld_err[i]));
        end
        set_req(1'b0, 3'd0, 16'h0, 5'h0, 32'h0, 2'd0);
        tick();

        // backpressure: A, B fill, C held
        out_ready = 1'b0;
        set_req(1'b1, 3'd1, 16'h000A, 5'h0, 32'h0, 2'd0);
        tick();
        set_req(1'b1, 3'd1, 16'h000B, 5'h0, 32'h0, 2'd0);
        tick();
        check("bp_full_count", 32'(count), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head_a", ext, 32'h0000000A);
        set_req(1'b1, 3'd1, 16'h000C, 5'h0, 32'h0, 2'd0);
        out_ready = 1'b1;
        tick();
        check("bp_count_after_a", 32'(count), 32'd1);
        check("bp_head_b", ext, 32'h0000000B);
        tick();
        check("bp_count_after_b", 32'(count), 32'd1);
        check("bp_head_c", ext, 32'h0000000C);
        set_req(1'b0, 3'd0, 16'h0, 5'h0, 32'h0, 2'd0);
        tick();
        check("bp_empty_count", 32'(count), 32'd0);
        check("bp_empty_valid", 32'(out_valid), 32'd0);

        // flush beats a simultaneous push
        out_ready = 1'b0;
        set_req(1'b1, 3'd1, 16'h0007, 5'h0, 32'h0, 2'd0);
        tick();
        check("fl_pre_count", 32'(count), 32'd1);
        flush = 1'b1;
        set_req(1'b1, 3'd1, 16'h0005, 5'h0, 32'h0, 2'd0);
        tick();
        flush = 1'b0;
        set_req(1'b0, 3'd0, 16'h0, 5'h0, 32'h0, 2'd0);
        check("fl_count", 32'(count), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ext", ext, 32'h0);
        out_ready = 1'b1;
        tick();
        check("underflow_count", 32'(count), 32'd0);
        check("underflow_valid", 32'(out_valid), 32'd0);

        // simultaneous push/pop at count=1
        out_ready = 1'b0;
        set_req(1'b1, 3'd1, 16'h0100, 5'h0, 32'h0, 2'd0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("pp_head_before_%0d", i), ext, 32'h100 + 32'(i));
            set_req(1'b1, 3'd1, 16'h0101 + 16'(i), 5'h0, 32'h0, 2'd0);
            tick();
            check($sformatf("pp_count_%0d", i), 32'(count), 32'd1);
        end
        check("pp_last", ext, 32'h0000010A);

        // asynchronous reset mid-stream with a full buffer
        out_ready = 1'b0;
        set_req(1'b1, 3'd0, 16'hFFFF, 5'h0, 32'h0, 2'd0);
        tick();
        check("mid_full_count", 32'(count), 32'd2);
        set_req(1'b0, 3'd0, 16'h0, 5'h0, 32'h0, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ext", ext, 32'h0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
